// File: rtl/fetch_pc_if_id_stage.sv
// Instruction-fetch stage: PC/nPC pair with one delay slot, the IF/ID
// pipeline register feeding decode, and a saturating stall counter for debug.
module fetch_pc_if_id_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0000,
  parameter int          STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   PC_LE,
  input  logic                   nPC_LE,
  input  logic                   IF_ID_LE,
  input  logic                   ID_branch_taken,
  input  logic [31:0]            ID_target_addr,
  input  logic                   IF_ID_flush,
  input  logic [31:0]            imem_instr,
  output logic [31:0]            imem_addr,
  output logic [31:0]            PC_out,
  output logic [31:0]            nPC_out,
  output logic [31:0]            IF_ID_instr,
  output logic [31:0]            IF_ID_PC,
  output logic                   IF_ID_valid,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};

  logic [31:0]            pc_r;
  logic [31:0]            npc_r;
  logic [31:0]            ifid_instr_r;
  logic [31:0]            ifid_pc_r;
  logic                   ifid_valid_r;
  logic [STALL_CNT_W-1:0] stall_cnt_r;

  logic [31:0]            npc_next_s;
  logic [STALL_CNT_W-1:0] stall_cnt_next_s;

  // Next nPC: word-aligned branch target when taken, else sequential (wraps mod 2^32).
  always_comb begin
    npc_next_s = npc_r;
    if (ID_branch_taken) begin
      npc_next_s = {ID_target_addr[31:2], 2'b00};
    end else begin
      npc_next_s = npc_r + 32'd4;
    end
  end

  // Next stall count: count hold cycles of IF/ID, stick at all-ones.
  always_comb begin
    stall_cnt_next_s = stall_cnt_r;
    if (!IF_ID_LE && (stall_cnt_r != STALL_MAX)) begin
      stall_cnt_next_s = stall_cnt_r + STALL_ONE;
    end else begin
      stall_cnt_next_s = stall_cnt_r;
    end
  end

  // PC/nPC pair: PC takes the old nPC, so the delay-slot fetch always happens.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r  <= RESET_PC;
      npc_r <= RESET_PC + 32'd4;
    end else begin
      if (PC_LE) begin
        pc_r <= npc_r;
      end
      if (nPC_LE) begin
        npc_r <= npc_next_s;
      end
    end
  end

  // IF/ID register: flush beats hold, hold beats a normal load.
  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_instr_r <= NOP_INSTR;
      ifid_pc_r    <= 32'h0000_0000;
      ifid_valid_r <= 1'b0;
    end else if (IF_ID_flush) begin
      ifid_instr_r <= NOP_INSTR;
      ifid_pc_r    <= pc_r;
      ifid_valid_r <= 1'b0;
    end else if (IF_ID_LE) begin
      ifid_instr_r <= imem_instr;
      ifid_pc_r    <= pc_r;
      ifid_valid_r <= 1'b1;
    end
  end

  // Debug stall counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= {STALL_CNT_W{1'b0}};
    end else begin
      stall_cnt_r <= stall_cnt_next_s;
    end
  end

  assign imem_addr   = pc_r;
  assign PC_out      = pc_r;
  assign nPC_out     = npc_r;
  assign IF_ID_instr = ifid_instr_r;
  assign IF_ID_PC    = ifid_pc_r;
  assign IF_ID_valid = ifid_valid_r;
  assign stall_count = stall_cnt_r;

endmodule

// File: tb/tb_fetch_pc_if_id_stage.sv
// Self-checking bench for fetch_pc_if_id_stage: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a model.
module tb_fetch_pc_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        PC_LE, nPC_LE, IF_ID_LE;
  logic        ID_branch_taken;
  logic [31:0] ID_target_addr;
  logic        IF_ID_flush;
  logic [31:0] imem_instr;
  logic [31:0] imem_addr, PC_out, nPC_out, IF_ID_instr, IF_ID_PC;
  logic        IF_ID_valid;
  logic [15:0] stall_count;

  int errors = 0;
  int checks = 0;
  logic check_en = 1'b0;

  // model state
  logic [31:0] m_pc, m_npc, m_instr, m_ifpc;
  logic        m_valid;
  int          m_stall;

  always #5 clk = ~clk;

  // instruction memory: word at address A is A + 0x100
  assign imem_instr = imem_addr + 32'h0000_0100;

  fetch_pc_if_id_stage #(
    .RESET_PC(32'h0000_0000), .NOP_INSTR(NOP), .STALL_CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .PC_LE(PC_LE), .nPC_LE(nPC_LE), .IF_ID_LE(IF_ID_LE),
    .ID_branch_taken(ID_branch_taken), .ID_target_addr(ID_target_addr),
    .IF_ID_flush(IF_ID_flush), .imem_instr(imem_instr), .imem_addr(imem_addr),
    .PC_out(PC_out), .nPC_out(nPC_out), .IF_ID_instr(IF_ID_instr),
    .IF_ID_PC(IF_ID_PC), .IF_ID_valid(IF_ID_valid), .stall_count(stall_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what each register holds after the edge, from the rules.
  always @(posedge clk) begin
    logic [31:0] pc_old, npc_old;
    pc_old  = m_pc;
    npc_old = m_npc;
    if (reset) begin
      m_pc = 32'h0; m_npc = 32'h4;
      m_instr = NOP; m_ifpc = 32'h0; m_valid = 1'b0; m_stall = 0;
    end else begin
      if (PC_LE) m_pc = npc_old;
      if (nPC_LE) m_npc = ID_branch_taken ? (ID_target_addr & 32'hFFFF_FFFC) : npc_old + 32'd4;
      if (IF_ID_flush) begin
        m_instr = NOP; m_ifpc = pc_old; m_valid = 1'b0;
      end else if (IF_ID_LE) begin
        m_instr = pc_old + 32'h100; m_ifpc = pc_old; m_valid = 1'b1;
      end
      if (!IF_ID_LE) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
    end
  end

  // Compare process: every cycle once the model has seen a reset edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("imem_addr", imem_addr, m_pc);
      chk("PC_out", PC_out, m_pc);
      chk("nPC_out", nPC_out, m_npc);
      chk("IF_ID_instr", IF_ID_instr, m_instr);
      chk("IF_ID_PC", IF_ID_PC, m_ifpc);
      chk("IF_ID_valid", {31'd0, IF_ID_valid}, {31'd0, m_valid});
      chk("stall_count", {16'd0, stall_count}, m_stall[31:0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_en(input logic v);
    PC_LE = v; nPC_LE = v; IF_ID_LE = v;
  endtask

  initial begin
    reset = 1'b1; set_en(1'b0); ID_branch_taken = 1'b0;
    ID_target_addr = 32'h0; IF_ID_flush = 1'b0;
    @(negedge clk);
    tick();
    check_en = 1'b1;
    tick();
    // reset state
    chk("rst_pc", PC_out, 32'h0);
    chk("rst_npc", nPC_out, 32'h4);
    chk("rst_instr", IF_ID_instr, NOP);
    chk("rst_valid", {31'd0, IF_ID_valid}, 32'd0);
    chk("rst_stall", {16'd0, stall_count}, 32'd0);

    // sequential fetch
    reset = 1'b0; set_en(1'b1);
    tick();
    chk("seq1_pc", PC_out, 32'h4);
    chk("seq1_instr", IF_ID_instr, 32'h100);
    chk("seq1_valid", {31'd0, IF_ID_valid}, 32'd1);
    tick();
    chk("seq2_pc", PC_out, 32'h8);
    chk("seq2_instr", IF_ID_instr, 32'h104);
    chk("seq2_ifpc", IF_ID_PC, 32'h4);

    // taken branch at PC=8 to unaligned 0x43
    ID_branch_taken = 1'b1; ID_target_addr = 32'h0000_0043;
    tick();
    ID_branch_taken = 1'b0;
    chk("br_delay_pc", PC_out, 32'hC);
    chk("br_npc", nPC_out, 32'h40);
    chk("br_instr", IF_ID_instr, 32'h108);
    tick();
    chk("br_tgt_pc", PC_out, 32'h40);
    chk("br_slot_instr", IF_ID_instr, 32'h10C);
    tick();
    chk("br_tgt4_pc", PC_out, 32'h44);

    // branch to 0x10 to set up the stall scenario
    ID_branch_taken = 1'b1; ID_target_addr = 32'h10;
    tick();
    ID_branch_taken = 1'b0;
    tick();
    chk("pre_stall_pc", PC_out, 32'h10);

    // 2-cycle stall with a branch pending in ID
    set_en(1'b0); ID_branch_taken = 1'b1; ID_target_addr = 32'h80;
    tick();
    tick();
    chk("stall_pc", PC_out, 32'h10);
    chk("stall_npc", nPC_out, 32'h14);
    chk("stall_instr", IF_ID_instr, 32'h148);
    chk("stall_cnt2", {16'd0, stall_count}, 32'd2);
    set_en(1'b1);
    tick();
    ID_branch_taken = 1'b0;
    chk("unstall_pc", PC_out, 32'h14);
    chk("unstall_npc", nPC_out, 32'h80);
    chk("unstall_instr", IF_ID_instr, 32'h110);

    // flush while IF/ID is held
    IF_ID_LE = 1'b0; IF_ID_flush = 1'b1;
    tick();
    IF_ID_flush = 1'b0; IF_ID_LE = 1'b1;
    chk("flush_instr", IF_ID_instr, NOP);
    chk("flush_valid", {31'd0, IF_ID_valid}, 32'd0);
    chk("flush_ifpc", IF_ID_PC, 32'h14);

    // address wrap
    ID_branch_taken = 1'b1; ID_target_addr = 32'hFFFF_FFFF;
    tick();
    ID_branch_taken = 1'b0;
    chk("wrap_npc", nPC_out, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc", PC_out, 32'hFFFF_FFFC);
    chk("wrap_npc0", nPC_out, 32'h0);
    tick();
    chk("wrap_pc0", PC_out, 32'h0);
    chk("wrap_instr", IF_ID_instr, 32'h0000_00FC);

    // randomized traffic, checked by the compare process
    for (int i = 0; i < 3000; i++) begin
      int r;
      reset = ($urandom_range(0, 99) < 2);
      r = $urandom_range(0, 9);
      if (r < 7) set_en(1'b1);
      else if (r < 9) set_en(1'b0);
      else begin
        PC_LE = $urandom_range(0, 1); nPC_LE = $urandom_range(0, 1);
        IF_ID_LE = $urandom_range(0, 1);
      end
      ID_branch_taken = ($urandom_range(0, 4) == 0);
      ID_target_addr = $urandom;
      IF_ID_flush = ($urandom_range(0, 9) == 0);
      tick();
    end

    // long stall to saturate the counter, then reset mid-stall
    reset = 1'b0; set_en(1'b0); ID_branch_taken = 1'b0; IF_ID_flush = 1'b0;
    for (int i = 0; i < 65539; i++) tick();
    chk("sat_stall", {16'd0, stall_count}, 32'h0000_FFFF);
    reset = 1'b1;
    tick();
    chk("mid_rst_pc", PC_out, 32'h0);
    chk("mid_rst_npc", nPC_out, 32'h4);
    chk("mid_rst_instr", IF_ID_instr, NOP);
    chk("mid_rst_ifpc", IF_ID_PC, 32'h0);
    chk("mid_rst_valid", {31'd0, IF_ID_valid}, 32'd0);
    chk("mid_rst_stall", {16'd0, stall_count}, 32'd0);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_pc_if_id_stage.md
Name: fetch_pc_if_id_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. It holds the PC/nPC register pair with the delayed-branch (one delay slot) sequence and drives the instruction-memory address. It also implements the IF/ID pipeline register that feeds the decode stage, hazard/forwarding unit and control unit. It consumes the hazard unit's PC_LE, nPC_LE and IF_ID_LE, and the ID-stage branch/jump decision. It keeps a saturating stall counter for debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; nPC resets to RESET_PC+4.
NOP_INSTR, 32'h0000_0000, instruction word loaded into IF/ID on reset or flush.
STALL_CNT_W, 16, width of the stall counter.

Ports:
clk  input  1  rising-edge clock; the only clock.
reset  input  1  synchronous, active-high reset.
PC_LE  input  1  PC load enable from the hazard unit (0 = hold).
nPC_LE  input  1  nPC load enable from the hazard unit (0 = hold).
IF_ID_LE  input  1  IF/ID register load enable from the hazard unit (0 = hold).
ID_branch_taken  input  1  branch/jump in ID resolved taken this cycle.
ID_target_addr  input  32  branch/jump target computed in ID.
IF_ID_flush  input  1  load NOP_INSTR into IF/ID (annul).
imem_instr  input  32  instruction word read combinationally at imem_addr.
imem_addr  output  32  equals the current PC register.
PC_out  output  32  current PC register.
nPC_out  output  32  current nPC register.
IF_ID_instr  output  32  decode-stage instruction.
IF_ID_PC  output  32  PC of the instruction in IF_ID_instr.
IF_ID_valid  output  1  1 when IF_ID_instr came from a real fetch; 0 for reset/flush bubble.
stall_count  output  STALL_CNT_W  saturating count of cycles with IF_ID_LE=0.

Behaviour:
- Reset, evaluated at the clock edge, overrides everything: PC=RESET_PC, nPC=RESET_PC+4, IF_ID_instr=NOP_INSTR, IF_ID_PC=0, IF_ID_valid=0, stall_count=0. Asserting reset mid-operation, including during a stall or a taken branch, has the same effect.
- PC update (PC_LE=1): PC <= nPC. When PC_LE=0, PC holds.
- nPC update (nPC_LE=1):
  - nPC <= {ID_target_addr[31:2],2'b00} when ID_branch_taken=1.
  - Otherwise nPC <= nPC+4.
  - When nPC_LE=0, nPC holds and ID_branch_taken is ignored. The stalled branch stays in ID and is re-evaluated on the next cycle.
- Delayed branch: the instruction at PC+4 after a branch (the delay slot) is always fetched and passed to ID. The target is fetched on the cycle after that. There is no automatic annul.
- Address arithmetic is modulo 2^32: nPC 32'hFFFF_FFFC + 4 wraps to 0. Target bits [1:0] are forced to 0.
- IF/ID register, priority order:
  1. reset.
  2. IF_ID_flush=1: IF_ID_instr=NOP_INSTR, IF_ID_valid=0, IF_ID_PC=PC. Flush applies even when IF_ID_LE=0.
  3. IF_ID_LE=0: hold all IF/ID fields.
  4. Otherwise: IF_ID_instr <= imem_instr, IF_ID_PC <= PC, IF_ID_valid <= 1.
- Latency: an instruction appears on IF_ID_instr exactly one cycle after its PC is on imem_addr, absent stalls.
- stall_count increments on every non-reset cycle with IF_ID_LE=0 and saturates at all-ones (no wrap).
- PC_LE, nPC_LE and IF_ID_LE are normally equal. Each one gates only its own register, so a mismatch is not corrected.
- All outputs are registered except imem_addr, which is a wire copy of PC.

Test Plan:
1. Reset for 2 cycles, release, imem returns addr+32'h100 -> PC sequence 0,4,8,C. IF_ID_instr sequence NOP (valid=0), then 32'h100, 32'h104, 32'h108 with matching IF_ID_PC.
2. Sequential fetch, then ID_branch_taken=1 with target 32'h0000_0043 while PC=8 -> PC sequence 8, C (delay slot), 40, 44. Target bits [1:0] are cleared.
3. PC_LE=nPC_LE=IF_ID_LE=0 for 2 cycles at PC=10, with ID_branch_taken=1 during the stall -> PC, nPC and IF/ID are frozen. The branch is not taken until the enables return. stall_count=2.
4. IF_ID_flush=1 together with IF_ID_LE=0 -> IF_ID_instr=NOP_INSTR and IF_ID_valid=0 on the next cycle.
5. Preload a state where nPC=32'hFFFF_FFFC (via branch target), then run sequentially -> PC goes FFFF_FFFC, then 0.
6. Hold IF_ID_LE=0 for 2^STALL_CNT_W+3 cycles -> stall_count saturates at all-ones. Assert reset mid-stall -> all outputs return to their reset values on the next edge.
